// File: rtl/spi_slv_pkg.sv
// Shared types, constants and helpers for the SPI peripheral slave.
`timescale 1ns/1ps
package spi_slv_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_t;

    localparam int                SPI_SLV_BITS             = 8;
    localparam logic [2:0]        SPI_SLV_LAST_BIT         = 3'(SPI_SLV_BITS - 1);
    localparam logic [7:0]        SPI_SLV_UNDERRUN_DEFAULT = 8'hFF;

    // Maps "bits already transferred" to the bit position inside the byte.
    function automatic logic [2:0] bit_index(input logic [2:0] cnt, input logic lsb_first);
        if (lsb_first) begin
            return cnt;
        end else begin
            return 3'd7 - cnt;
        end
    endfunction

endpackage

// File: rtl/spi_peripheral_slave_if.sv
// Bus bundle between the SPI slave and its serial master / local logic.
`timescale 1ns/1ps
interface spi_peripheral_slave_if;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       rx_ovr_clr;
    logic       tx_underrun;
    logic       busy;

    modport slave (
        input  sclk, ss, mosi, cpol, cpha, lsbfe, tx_data, tx_valid, rx_ack, rx_ovr_clr,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, busy
    );

    modport master (
        output sclk, ss, mosi, cpol, cpha, lsbfe, tx_data, tx_valid, rx_ack, rx_ovr_clr,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slv_sync.sv
// Multi-flop synchronizer with rise/fall pulses derived from the synchronized level.
`timescale 1ns/1ps
module spi_slv_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Shift the asynchronous input through the chain and remember the previous level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= {STAGES{RESET_VAL}};
            prev_r  <= RESET_VAL;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign q    = chain_r[STAGES-1];
    assign rise = chain_r[STAGES-1] & ~prev_r;
    assign fall = ~chain_r[STAGES-1] & prev_r;
endmodule

// File: rtl/spi_peripheral_slave.sv
// Byte-oriented SPI slave: all CPOL/CPHA modes, MSB/LSB first, one-deep TX and RX holding.
// Optional feature macro: SPI_SLV_OVERRUN_EN (drop new bytes while rx_valid is pending).
`timescale 1ns/1ps
import spi_slv_pkg::*;

module spi_peripheral_slave #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] UNDERRUN_BYTE = SPI_SLV_UNDERRUN_DEFAULT
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    spi_peripheral_slave_if.slave sp
);
    spi_slv_state_t state_r, state_next_s;

    logic sclk_sync_unused_s, ss_sync_unused_s, mosi_rise_unused_s, mosi_fall_unused_s;
    logic sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s, mosi_s;

    logic lead_s, trail_s, entry_s, exit_s, run_s, sample_s, shift_s, done_s, byte_start_s;
    logic [SPI_SLV_BITS-1:0] rx_next_s, start_byte_s;

    logic [2:0]              bit_cnt_r;
    logic [SPI_SLV_BITS-1:0] tx_shift_r, hold_data_r, rx_shift_r, rx_data_r;
    logic                    hold_full_r, miso_r, rx_valid_r, tx_underrun_r;

    spi_slv_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(PCLK), .rst(PRESET), .d(sp.sclk),
        .q(sclk_sync_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_slv_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk(PCLK), .rst(PRESET), .d(sp.ss),
        .q(ss_sync_unused_s), .rise(ss_rise_s), .fall(ss_fall_s)
    );
    spi_slv_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(PCLK), .rst(PRESET), .d(sp.mosi),
        .q(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
    );

    // FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: select opens a frame, deselect closes it from any bit position.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (ss_fall_s) state_next_s = ACTIVE; else state_next_s = IDLE;
            ACTIVE:  if (ss_rise_s) state_next_s = IDLE;   else state_next_s = ACTIVE;
            default: state_next_s = IDLE;
        endcase
    end

    // Decode mode-dependent edges into sample/shift/byte-start strobes.
    always_comb begin
        lead_s       = sp.cpol ? sclk_fall_s : sclk_rise_s;
        trail_s      = sp.cpol ? sclk_rise_s : sclk_fall_s;
        entry_s      = (state_r == IDLE) && ss_fall_s;
        exit_s       = (state_r == ACTIVE) && ss_rise_s;
        run_s        = (state_r == ACTIVE) && !ss_rise_s;
        sample_s     = run_s && (sp.cpha ? trail_s : lead_s);
        // In CPHA=0 the first bit is already on miso at byte start, so the trailing
        // edge right after a byte boundary must not advance it again.
        shift_s      = run_s && (sp.cpha ? lead_s : (trail_s && (bit_cnt_r != 3'd0)));
        done_s       = sample_s && (bit_cnt_r == SPI_SLV_LAST_BIT);
        byte_start_s = entry_s || done_s;
        rx_next_s    = sp.lsbfe ? {mosi_s, rx_shift_r[SPI_SLV_BITS-1:1]}
                                : {rx_shift_r[SPI_SLV_BITS-2:0], mosi_s};
        start_byte_s = hold_full_r ? hold_data_r : UNDERRUN_BYTE;
    end

    // Serial engine: bit counter, TX shift register, miso and the underrun pulse.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            bit_cnt_r     <= 3'd0;
            tx_shift_r    <= 8'h00;
            rx_shift_r    <= 8'h00;
            miso_r        <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            tx_underrun_r <= 1'b0;
            if (exit_s) begin
                bit_cnt_r <= 3'd0;
                miso_r    <= 1'b0;
            end else if (byte_start_s) begin
                bit_cnt_r     <= 3'd0;
                tx_shift_r    <= start_byte_s;
                miso_r        <= start_byte_s[bit_index(3'd0, sp.lsbfe)];
                tx_underrun_r <= !hold_full_r;
            end else if (sample_s) begin
                bit_cnt_r  <= bit_cnt_r + 3'd1;
                rx_shift_r <= rx_next_s;
            end else if (shift_s) begin
                miso_r <= tx_shift_r[bit_index(bit_cnt_r, sp.lsbfe)];
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // TX holding register: filled by the local handshake, emptied by a byte start.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            hold_full_r <= 1'b0;
            hold_data_r <= 8'h00;
        end else if (byte_start_s && hold_full_r) begin
            hold_full_r <= 1'b0;
        end else if (sp.tx_valid && !hold_full_r) begin
            hold_full_r <= 1'b1;
            hold_data_r <= sp.tx_data;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    // RX holding register: a completing byte wins over a same-cycle acknowledge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else if (done_s) begin
`ifdef SPI_SLV_OVERRUN_EN
            if (rx_valid_r && !sp.rx_ack) begin
                rx_data_r <= rx_data_r;
            end else begin
                rx_data_r  <= rx_next_s;
                rx_valid_r <= 1'b1;
            end
`else
            rx_data_r  <= rx_next_s;
            rx_valid_r <= 1'b1;
`endif
        end else if (sp.rx_ack && rx_valid_r) begin
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= rx_valid_r;
        end
    end

`ifdef SPI_SLV_OVERRUN_EN
    logic rx_overrun_r;

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_overrun_r <= 1'b0;
        end else if (done_s && rx_valid_r && !sp.rx_ack) begin
            rx_overrun_r <= 1'b1;
        end else if (sp.rx_ovr_clr) begin
            rx_overrun_r <= 1'b0;
        end else begin
            rx_overrun_r <= rx_overrun_r;
        end
    end

    assign sp.rx_overrun = rx_overrun_r;
`else
    logic ovr_clr_unused_s;
    assign ovr_clr_unused_s = sp.rx_ovr_clr;
    assign sp.rx_overrun    = 1'b0;
`endif

    assign sp.miso        = miso_r;
    assign sp.miso_oe     = (state_r == ACTIVE);
    assign sp.busy        = (state_r == ACTIVE);
    assign sp.tx_ready    = !hold_full_r;
    assign sp.rx_data     = rx_data_r;
    assign sp.rx_valid    = rx_valid_r;
    assign sp.tx_underrun = tx_underrun_r;
endmodule

// File: tb/tb_spi_peripheral_slave.sv
// Directed + randomized bench for spi_peripheral_slave with a transaction-level model.
`timescale 1ns/1ps
module tb_spi_peripheral_slave;
    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic PCLK = 1'b0;
    logic PRESET;
    int   total = 0;
    int   bad   = 0;

    always #5 PCLK = ~PCLK;

    spi_peripheral_slave_if sif();

    spi_peripheral_slave #(.SYNC_STAGES(SYNC), .UNDERRUN_BYTE(8'hFF)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .sp(sif)
    );

    // Model state: held TX bytes, expected RX register, expected underrun count.
    logic [7:0] hold_q[$];
    logic [7:0] exp_rx_data;
    logic       exp_rx_valid;
    logic       exp_ovr;
    int         exp_und = 0;
    logic [7:0] mo[4];

    // Observations gathered independently of the checking thread.
    int   und_cnt = 0;
    logic rxv_prev = 1'b0;
    time  rxv_rise_t = 0;
    time  last_samp_t = 0;

    always @(negedge PCLK) begin
        if (sif.tx_underrun === 1'b1) und_cnt <= und_cnt + 1;
        rxv_prev <= sif.rx_valid;
        if (sif.rx_valid === 1'b1 && rxv_prev !== 1'b1) rxv_rise_t <= $time;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hold_q.delete();
        exp_rx_data  = 8'h00;
        exp_rx_valid = 1'b0;
        exp_ovr      = 1'b0;
    endtask

    // Every byte start takes the held byte, or the underrun filler with a pulse.
    task automatic model_start(output logic [7:0] b);
        if (hold_q.size() > 0) begin
            b = hold_q.pop_front();
        end else begin
            b = 8'hFF;
            exp_und++;
        end
    endtask

    task automatic model_rx(input logic [7:0] b);
`ifdef SPI_SLV_OVERRUN_EN
        if (exp_rx_valid) exp_ovr = 1'b1;
        else begin
            exp_rx_data  = b;
            exp_rx_valid = 1'b1;
        end
`else
        exp_rx_data  = b;
        exp_rx_valid = 1'b1;
`endif
    endtask

    task automatic half();
        repeat (HALF) @(negedge PCLK);
    endtask

    task automatic preload(input logic [7:0] d);
        int n = 0;
        while (sif.tx_ready !== 1'b1 && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        chk("tx_ready_before_load", sif.tx_ready, 1);
        sif.tx_data  = d;
        sif.tx_valid = 1'b1;
        @(negedge PCLK);
        sif.tx_valid = 1'b0;
        hold_q.push_back(d);
        chk("tx_ready_after_load", sif.tx_ready, 0);
    endtask

    // Master side of one byte (or its first nbits), sampling miso at the master's edge.
    task automatic xfer_byte(input logic [7:0] b, input int nbits, output logic [7:0] got);
        int idx;
        got = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            idx = sif.lsbfe ? k : 7 - k;
            if (sif.cpha == 1'b0) begin
                sif.mosi = b[idx];
                half();
                sif.sclk = ~sif.sclk;
                got[idx] = sif.miso;
                if (k == 7) last_samp_t = $time;
                half();
                sif.sclk = ~sif.sclk;
            end else begin
                sif.sclk = ~sif.sclk;
                sif.mosi = b[idx];
                half();
                sif.sclk = ~sif.sclk;
                got[idx] = sif.miso;
                if (k == 7) last_samp_t = $time;
                half();
            end
        end
    endtask

    task automatic check_idle();
        chk("busy_idle", sif.busy, 0);
        chk("miso_oe_idle", sif.miso_oe, 0);
        chk("miso_idle", sif.miso, 0);
        chk("rx_data", sif.rx_data, exp_rx_data);
        chk("rx_valid", sif.rx_valid, exp_rx_valid);
        chk("rx_overrun", sif.rx_overrun, exp_ovr);
        chk("tx_underrun_count", und_cnt, exp_und);
        chk("tx_ready", sif.tx_ready, (hold_q.size() == 0) ? 1 : 0);
    endtask

    // A full frame of n bytes from mo[]; the final sample also triggers a byte start.
    task automatic run_frame(input int n);
        logic [7:0] got, expm;
        sif.ss = 1'b0;
        model_start(expm);
        half();
        chk("miso_oe_active", sif.miso_oe, 1);
        for (int i = 0; i < n; i++) begin
            xfer_byte(mo[i], 8, got);
            chk("miso_byte", got, expm);
            model_rx(mo[i]);
            model_start(expm);
        end
        half();
        sif.ss = 1'b1;
        repeat (10) @(negedge PCLK);
        check_idle();
    endtask

    task automatic ack();
        sif.rx_ack = 1'b1;
        @(negedge PCLK);
        sif.rx_ack = 1'b0;
        exp_rx_valid = 1'b0;
        chk("rx_valid_after_ack", sif.rx_valid, 0);
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic lsb);
        sif.cpol  = pol;
        sif.cpha  = pha;
        sif.lsbfe = lsb;
        sif.sclk  = pol;
        repeat (10) @(negedge PCLK);
    endtask

    task automatic check_reset_values();
        chk("rst_miso", sif.miso, 0);
        chk("rst_miso_oe", sif.miso_oe, 0);
        chk("rst_tx_ready", sif.tx_ready, 1);
        chk("rst_rx_data", sif.rx_data, 8'h00);
        chk("rst_rx_valid", sif.rx_valid, 0);
        chk("rst_rx_overrun", sif.rx_overrun, 0);
        chk("rst_tx_underrun", sif.tx_underrun, 0);
        chk("rst_busy", sif.busy, 0);
    endtask

    initial begin
        logic [7:0] got, expm;
        logic [7:0] t;
        PRESET         = 1'b1;
        sif.sclk       = 1'b0;
        sif.ss         = 1'b1;
        sif.mosi       = 1'b0;
        sif.cpol       = 1'b0;
        sif.cpha       = 1'b0;
        sif.lsbfe      = 1'b0;
        sif.tx_data    = 8'h00;
        sif.tx_valid   = 1'b0;
        sif.rx_ack     = 1'b0;
        sif.rx_ovr_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge PCLK);
        check_reset_values();
        PRESET = 1'b0;
        repeat (5) @(negedge PCLK);

        // Mode 0, MSB first, preloaded A5 against master byte 3C.
        preload(8'hA5);
        mo[0] = 8'h3C;
        run_frame(1);
        chk("rx_valid_latency", 32'(rxv_rise_t - last_samp_t), 32'((SYNC + 1) * 10));
        ack();

        // Every CPOL/CPHA/LSBFE combination: fixed 81 then a random byte.
        for (int m = 0; m < 8; m++) begin
            set_mode(m[1], m[0], m[2]);
            t = 8'($urandom);
            preload(t);
            mo[0] = 8'h81;
            run_frame(1);
            ack();
            mo[0] = 8'($urandom);
            run_frame(1);
            ack();
        end

        // Two-byte frame, one held TX byte, no acknowledge between bytes.
        set_mode(1'b0, 1'b0, 1'b0);
        preload(8'($urandom));
        mo[0] = 8'h11;
        mo[1] = 8'h22;
        run_frame(2);
        sif.rx_ovr_clr = 1'b1;
        @(negedge PCLK);
        sif.rx_ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        chk("rx_overrun_cleared", sif.rx_overrun, 0);
        ack();

        // Deselect after four bits, then a complete frame.
        set_mode(1'b1, 1'b1, 1'b0);
        sif.ss = 1'b0;
        model_start(expm);
        half();
        xfer_byte(8'($urandom), 4, got);
        half();
        sif.ss = 1'b1;
        repeat (10) @(negedge PCLK);
        check_idle();
        preload(8'($urandom));
        mo[0] = 8'($urandom);
        run_frame(1);
        ack();

        // Reset in the middle of a byte, then a normal frame.
        set_mode(1'b0, 1'b1, 1'b1);
        mo[0] = 8'($urandom);
        run_frame(1);
        preload(8'($urandom));
        sif.ss = 1'b0;
        model_start(expm);
        half();
        xfer_byte(8'($urandom), 3, got);
        @(negedge PCLK);
        #2 PRESET = 1'b1;
        #1 check_reset_values();
        model_reset();
        sif.ss   = 1'b1;
        sif.sclk = sif.cpol;
        sif.mosi = 1'b0;
        repeat (4) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (5) @(negedge PCLK);
        preload(8'($urandom));
        mo[0] = 8'($urandom);
        run_frame(1);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
